qreverse: RTL and testbench
===========================

# qreverse

Transaction reverser for eot-terminated DTI queues. It accepts one transaction on `din`, stores it in local RAM, then replays it on `dout` in reverse order, with the eot flag regenerated on the new last item. It sits downstream of `fifo` in stream pipelines where a consumer needs last-in-first-out order within each transaction.

## Interface
- `DEPTH`, 64: maximum items per transaction; power of two, ≥2.
- `DIN`, 16: `din`/`dout` data width, including the eot bit.

- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `din`  dti.consumer  `DIN`  input transaction stream.
  - `data[DIN-1]` = eot.
  - `data[DIN-2:0]` = payload.
- `dout`  dti.producer  `DIN`  reversed stream, same data layout.

## Operation
- Internal widths:
  - `CW = $clog2(DEPTH)`.
  - `cnt` is `CW+1` bits: items stored.
  - `rptr` is `CW` bits: read index.
- **FILL state**
  - `din.ready = 1`.
  - On a handshake: `ram[cnt] <= payload`, `cnt <= cnt+1`.
  - The handshake closes the transaction if `din.eot = 1` or `cnt == DEPTH-1`. On close: `rptr <= cnt[CW-1:0]`, next state DRAIN.
  - A transaction truncated at DEPTH items is closed with no error indication unless the overflow flag is enabled (see Configuration). The next input item starts a new transaction.
- **DRAIN state**
  - `din.ready = 0`.
  - Read side presents `{rptr == 0, ram[rptr]}`.
  - On a read handshake: if `rptr == 0`, then `cnt <= 0` and next state FILL; else `rptr <= rptr-1`.
- Output item k of a transaction (k = 0..N-1) is input item N-1-k. Only output item N-1 carries eot=1.
- Single-item transaction (eot on the first item): output is that item with eot=1.
- `dout.valid` may rise only in DRAIN and is held until `dout.ready`. `dout.data` is stable while valid and not ready.
- `dout.valid` does not depend combinationally on `dout.ready`.
- Reset values:
  - State FILL; `cnt = 0`; `rptr = 0`.
  - `dout.valid = 0`; `din.ready = 1` in the first cycle after reset.
  - RAM contents are not reset.
- Reset asserted mid-transaction, in FILL or DRAIN: the partial transaction is discarded and the state above applies on the next cycle.

## Timing
- The RAM read is asynchronous, as in `fifo` without REGOUT.
- Eot accepted at cycle t: `dout.valid = 1` at t+1, carrying the item accepted at t.
- Read throughput: one item per cycle while `dout.ready = 1`.
- Last output handshake at cycle u: `din.ready = 1` at u+1.
- Minimum period for an N-item transaction: 2N cycles. Input and output never overlap.
- Backpressure: `dout.ready = 0` freezes `rptr`, `dout.data` and the state.

## Configuration
- Macro: `QREVERSE_OVF_EN`.
- Defined:
  - Adds output port `ovf` (1 bit), reset 0.
  - `ovf` is set in the cycle after a transaction is closed by `cnt == DEPTH-1` with `din.eot = 0`.
  - `ovf` is sticky until `rst`.
- Undefined: port absent; truncation is silent.
- Datapath timing is identical in both builds.

## Structure
- `qreverse_pkg` holds:
  - `typedef enum logic {FILL, DRAIN} qreverse_state_t`.
  - Localparam helpers for `CW` and the eot bit index.
- Sub-module `qreverse_ram`:
  - `DEPTH` × `DIN-1` bits.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One asynchronous read port (`raddr`, `rdata`).
- The top module holds the FSM, `cnt`, `rptr` and the eot regeneration.

## Test plan
- Send 1,2,3,4 with eot on 4, `dout.ready = 1`: output 4,3,2,1; eot only on 1; `din.ready = 0` for exactly 4 cycles.
- Single item 0x55 with eot: one output 0x55, eot=1, valid the cycle after accept.
- `DEPTH = 8`, send 10 items without eot: first output 7..0 with eot on 0, then items 8,9 start a new transaction. With `QREVERSE_OVF_EN`, `ovf = 1` after the 8th accept.
- Random `dout.ready` (50%) over 3-item transaction A,B,C: output C,B,A. Data holds stable while valid and not ready. No loss or duplication.
- Assert `rst` in DRAIN after one output item: `dout.valid = 0` and `din.ready = 1` the next cycle. A fresh transaction 9,8 reverses to 8,9.
- Back-to-back transactions of lengths 1, 64 and 3 with random valid gaps: all reverse correctly; eot count equals transaction count.

Source files
------------

// File: rtl/qreverse_pkg.sv
// Shared types and width helpers for the qreverse transaction reverser.
package qreverse_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } qreverse_state_t;

    localparam int unsigned DefaultDepth = 64;
    localparam int unsigned DefaultDin   = 16;

    // Index width for a RAM of the given depth; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned eot_bit(input int unsigned din_w);
        return din_w - 1;
    endfunction

endpackage

// File: rtl/qreverse_ram.sv
// Item storage for qreverse: synchronous write port, asynchronous read port.
module qreverse_ram
    import qreverse_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WIDTH = DefaultDin - 1,
    localparam int unsigned AW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/qreverse.sv
// Reverses eot-terminated DTI transactions (LIFO within each transaction).
// Optional QREVERSE_OVF_EN adds a sticky ovf flag for transactions truncated at DEPTH.
module qreverse
    import qreverse_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned DIN   = DefaultDin
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DIN-1:0] dout_data
`ifdef QREVERSE_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam int unsigned CW     = cnt_width(DEPTH);
    localparam int unsigned EotBit = eot_bit(DIN);
    localparam int unsigned PW     = DIN - 1;
    localparam logic [CW:0] LastCnt = (CW + 1)'(DEPTH - 1);

    qreverse_state_t state_q, state_d;
    logic [CW:0]     cnt_q, cnt_d;
    logic [CW-1:0]   rptr_q, rptr_d;
    logic            ram_we;
    logic            close;
    logic [PW-1:0]   rdata;

    qreverse_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cnt_q[CW-1:0]),
        .wdata (din_data[PW-1:0]),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rptr_d     = rptr_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        ram_we     = 1'b0;
        close      = 1'b0;
        unique case (state_q)
            FILL: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    // A full RAM closes the transaction even without eot.
                    if (din_data[EotBit] || (cnt_q == LastCnt)) begin
                        close   = 1'b1;
                        rptr_d  = cnt_q[CW-1:0];
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    if (rptr_q == '0) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        rptr_d = rptr_q - 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Eot is regenerated: the item at index 0 is always the last one replayed.
    assign dout_data = {(rptr_q == '0), rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rptr_q  <= rptr_d;
        end
    end

`ifdef QREVERSE_OVF_EN
    logic ovf_q, ovf_d;

    // Closing without eot can only happen through truncation.
    always_comb begin
        ovf_d = ovf_q | (close & ~din_data[EotBit]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_qreverse.sv
// Self-checking bench for qreverse: DEPTH=64 and DEPTH=8 instances, reference model in queues.
module tb_qreverse;

    localparam int unsigned DIN = 16;
    localparam int unsigned PW  = DIN - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    bit             sel;
    logic           din_valid;
    logic [DIN-1:0] din_data;
    logic           dout_ready;

    logic           din_valid_a, din_ready_a, dout_valid_a;
    logic [DIN-1:0] dout_data_a;
    logic           din_valid_b, din_ready_b, dout_valid_b;
    logic [DIN-1:0] dout_data_b;
    logic           cur_din_ready, cur_dout_valid;
    logic [DIN-1:0] cur_dout_data;

    assign din_valid_a    = din_valid & ~sel;
    assign din_valid_b    = din_valid & sel;
    assign cur_din_ready  = sel ? din_ready_b  : din_ready_a;
    assign cur_dout_valid = sel ? dout_valid_b : dout_valid_a;
    assign cur_dout_data  = sel ? dout_data_b  : dout_data_a;

`ifdef QREVERSE_OVF_EN
    logic ovf_a, ovf_b;
`endif

    qreverse #(
        .DEPTH (64),
        .DIN   (DIN)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid_a),
        .din_ready  (din_ready_a),
        .din_data   (din_data),
        .dout_valid (dout_valid_a),
        .dout_ready (dout_ready),
        .dout_data  (dout_data_a)
`ifdef QREVERSE_OVF_EN
        ,
        .ovf        (ovf_a)
`endif
    );

    qreverse #(
        .DEPTH (8),
        .DIN   (DIN)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid_b),
        .din_ready  (din_ready_b),
        .din_data   (din_data),
        .dout_valid (dout_valid_b),
        .dout_ready (dout_ready),
        .dout_data  (dout_data_b)
`ifdef QREVERSE_OVF_EN
        ,
        .ovf        (ovf_b)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DIN-1:0] stim_q[$];
    logic [DIN-1:0] exp_q[$];

    task automatic do_reset();
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives stim_q into the selected instance and checks every output against the model.
    task automatic run_stream(input bit s, input int valid_pct, input int ready_pct,
                              output int rdy_low, output int eots);
        int unsigned depth = s ? 8 : 64;
        logic [PW-1:0] cur_txn[$];
        int cyc = 0;
        int idx = 0;
        bit closed_prev = 1'b0;
        sel     = s;
        rdy_low = 0;
        eots    = 0;
        exp_q.delete();
        while ((idx < stim_q.size() || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (cur_din_ready && cur_dout_valid) begin
                n_errors++;
                $display("FAIL overlap: din_ready=1 and dout_valid=1 together (cycle %0d)", cyc);
            end
            if (closed_prev) begin
                n_checks++;
                if (cur_dout_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL close_latency: dout_valid=%b, required 1", cur_dout_valid);
                end
            end
            if (!cur_din_ready) rdy_low++;
            dout_ready = ($urandom_range(99) < ready_pct);
            if (cur_dout_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL spurious_out: got %h, no item expected", cur_dout_data);
                end else begin
                    if (cur_dout_data !== exp_q[0]) begin
                        n_errors++;
                        $display("FAIL dout_data: got %h, required %h", cur_dout_data, exp_q[0]);
                    end
                    if (dout_ready) begin
                        if (cur_dout_data[DIN-1]) eots++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            closed_prev = 1'b0;
            if (idx < stim_q.size() && $urandom_range(99) < valid_pct) begin
                din_valid = 1'b1;
                din_data  = stim_q[idx];
            end else begin
                din_valid = 1'b0;
                din_data  = DIN'($urandom);
            end
            if (din_valid && cur_din_ready) begin
                cur_txn.push_back(stim_q[idx][PW-1:0]);
                if (stim_q[idx][DIN-1] || cur_txn.size() == depth) begin
                    for (int k = int'(cur_txn.size()) - 1; k >= 0; k--) begin
                        exp_q.push_back({(k == 0), cur_txn[k]});
                    end
                    cur_txn.delete();
                    closed_prev = 1'b1;
                end
                idx++;
            end
        end
        if (cyc >= 4000) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: %0d items left, required 0", exp_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (cur_din_ready !== 1'b1 || cur_dout_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL after_drain: din_ready=%b dout_valid=%b, required 1/0",
                     cur_din_ready, cur_dout_valid);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic check_eots(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: eot count %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dout_valid_a !== 1'b0 || din_ready_a !== 1'b1 ||
            dout_valid_b !== 1'b0 || din_ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: a v/r=%b/%b b v/r=%b/%b, required 0/1",
                     dout_valid_a, din_ready_a, dout_valid_b, din_ready_b);
        end
`ifdef QREVERSE_OVF_EN
        n_checks++;
        if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ovf: %b/%b, required 0/0", ovf_a, ovf_b);
        end
`endif
    endtask

    task automatic test_basic();
        int low, eots;
        stim_q = '{16'h0001, 16'h0002, 16'h0003, 16'h8004};
        run_stream(1'b0, 100, 100, low, eots);
        check_eots("basic_eot", eots, 1);
        n_checks++;
        if (low != 4) begin
            n_errors++;
            $display("FAIL basic_ready_low: %0d cycles, required 4", low);
        end
    endtask

    task automatic test_single();
        int low, eots;
        stim_q = '{16'h8055};
        run_stream(1'b0, 100, 100, low, eots);
        check_eots("single_eot", eots, 1);
    endtask

    task automatic test_truncate();
        int low, eots;
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back(DIN'(i));
        stim_q.push_back(16'h800a);
        run_stream(1'b1, 100, 100, low, eots);
        check_eots("truncate_eot", eots, 2);
`ifdef QREVERSE_OVF_EN
        n_checks++;
        if (ovf_b !== 1'b1 || ovf_a !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_set: b=%b a=%b, required 1/0", ovf_b, ovf_a);
        end
`endif
    endtask

    task automatic test_random_ready();
        int low, eots;
        for (int r = 0; r < 4; r++) begin
            stim_q = '{{1'b0, PW'($urandom)}, {1'b0, PW'($urandom)}, {1'b1, PW'($urandom)}};
            run_stream(1'b0, 100, 50, low, eots);
            check_eots("random_ready_eot", eots, 1);
        end
    endtask

    task automatic test_reset_in_drain();
        int low, eots;
        sel        = 1'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din_data  = (i == 2) ? 16'h8003 : DIN'(i + 1);
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_checks++;
        if (dout_valid_a !== 1'b1 || dout_data_a !== 16'h0003) begin
            n_errors++;
            $display("FAIL drain_first: v=%b data=%h, required 1/0003", dout_valid_a, dout_data_a);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid_a !== 1'b1 || dout_data_a !== 16'h0002) begin
            n_errors++;
            $display("FAIL drain_second: v=%b data=%h, required 1/0002", dout_valid_a, dout_data_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (dout_valid_a !== 1'b0 || din_ready_a !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_drain: v=%b r=%b, required 0/1", dout_valid_a, din_ready_a);
        end
`ifdef QREVERSE_OVF_EN
        n_checks++;
        if (ovf_b !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: %b, required 0", ovf_b);
        end
`endif
        stim_q = '{16'h0009, 16'h8008};
        run_stream(1'b0, 100, 100, low, eots);
        check_eots("post_reset_eot", eots, 1);
    endtask

    task automatic test_back_to_back();
        int low, eots;
        int lens[3] = '{1, 64, 3};
        int n_txn;
        stim_q.delete();
        foreach (lens[t]) begin
            for (int i = 0; i < lens[t]; i++) begin
                stim_q.push_back({(i == lens[t] - 1), PW'($urandom)});
            end
        end
        run_stream(1'b0, 70, 80, low, eots);
        check_eots("b2b_eot", eots, 3);
        stim_q.delete();
        n_txn = 6;
        for (int t = 0; t < n_txn; t++) begin
            int len = int'($urandom_range(8, 1));
            for (int i = 0; i < len; i++) begin
                stim_q.push_back({(i == len - 1), PW'($urandom)});
            end
        end
        run_stream(1'b1, 60, 60, low, eots);
        check_eots("b2b_small_eot", eots, n_txn);
    endtask

    initial begin
        sel        = 1'b0;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_truncate();
        test_random_ready();
        test_reset_in_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
